// File: rtl/key_pkg.sv
// Shared types and 25 MHz default timing for the keypad debouncer.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } key_st_t;

  localparam int DEF_DEBOUNCE_CYC     = 250_000;     // 10 ms
  localparam int DEF_REPEAT_DELAY_CYC = 12_500_000;  // 500 ms
  localparam int DEF_REPEAT_RATE_CYC  = 2_500_000;   // 100 ms

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, debounce FSM and, with KEY_REPEAT_EN defined,
// an auto-repeat counter. press_nxt_o exposes the press pulse before its flop.
module key_debounce_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic press_nxt_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  if (DEBOUNCE_CYC < 2 || REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_cfg
    $error("key_debounce_cell: illegal timing parameters");
  end

  logic          sync1_q, sync2_q;
  key_st_t       st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (st_q)
      IDLE: if (!sync2_q) begin
        st_d  = PRESS_WAIT;
        cnt_d = '0;
      end
      PRESS_WAIT: begin
        if (sync2_q) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d    = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
          state_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: if (sync2_q) begin
        st_d  = REL_WAIT;
        cnt_d = '0;
      end
      REL_WAIT: begin
        if (!sync2_q) begin
          st_d  = HELD;
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          st_d    = IDLE;
          cnt_d   = '0;
          rel_d   = 1'b1;
          state_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      st_q    <= IDLE;
      cnt_q   <= '0;
      state_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign state_o     = state_q;
  assign press_o     = press_q;
  assign release_o   = rel_q;
  assign press_nxt_o = press_d;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_CYC - 1);

  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          armed_q, armed_d;  // first repeat already fired
  logic          rpt_q, rpt_d;

  // Counts only cycles that stay in HELD, so it freezes across a release bounce.
  always_comb begin
    rcnt_d  = rcnt_q;
    armed_d = armed_q;
    rpt_d   = 1'b0;
    if (press_d || st_d == IDLE) begin
      rcnt_d  = '0;
      armed_d = 1'b0;
    end else if (st_q == HELD && st_d == HELD) begin
      if (rcnt_q == (armed_q ? RATE_LAST : DELAY_LAST)) begin
        rpt_d   = 1'b1;
        rcnt_d  = '0;
        armed_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt_q  <= '0;
      armed_q <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      armed_q <= armed_d;
      rpt_q   <= rpt_d;
    end
  end

  assign repeat_o = rpt_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// N_KEYS independent debounce cells plus a registered lowest-index press encoder.
// Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int N_KEYS           = 4,
  parameter int DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC,
  localparam int CODE_W          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_repeat,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code
);

  logic [N_KEYS-1:0] press_nxt;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYC    (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_i      (key_in[g]),
      .state_o    (key_state[g]),
      .press_o    (key_press[g]),
      .release_o  (key_release[g]),
      .repeat_o   (key_repeat[g]),
      .press_nxt_o(press_nxt[g])
    );
  end

  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;

  // Encode the cells' next-cycle press so valid/code line up with key_press.
  always_comb begin
    valid_d = |press_nxt;
    code_d  = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (press_nxt[i]) code_d = CODE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Randomised and directed bench for key_debounce_array with a run-length model.
module tb_key_debounce_array;

  localparam int N = 4;
  localparam int D = 16;
  localparam int RDLY = 64;
  localparam int RRATE = 32;
`ifdef KEY_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state, key_press, key_release, key_repeat;
  logic         key_valid;
  logic [1:0]   key_code;

  int tests = 0;
  int fails = 0;

  key_debounce_array #(
    .N_KEYS(N), .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RDLY), .REPEAT_RATE_CYC(RRATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .key_repeat(key_repeat),
    .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the synced level must disagree with the accepted level for D+1
  // consecutive samples before it is accepted; repeats are timed by the
  // number of stable-held cycles since the press.
  logic         m_s1 [N];
  logic         m_s2 [N];
  logic         m_lvl[N];
  int           m_run[N];
  int           m_t  [N];
  logic [N-1:0] m_state, m_press, m_rel, m_rpt;
  logic         m_valid;
  logic [1:0]   m_code;
  bit           mdl_on = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mdl_on = 1'b1;
        for (int k = 0; k < N; k++) begin
          m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_lvl[k] = 1'b0; m_run[k] = 0; m_t[k] = 0;
        end
        m_state = '0; m_press = '0; m_rel = '0; m_rpt = '0; m_valid = 1'b0; m_code = '0;
      end else if (mdl_on) begin
        m_press = '0; m_rel = '0; m_rpt = '0;
        for (int k = 0; k < N; k++) begin
          logic want;
          want = ~m_s2[k];
          if (want != m_lvl[k]) begin
            m_run[k]++;
            if (m_run[k] == D + 1) begin
              m_lvl[k] = want; m_run[k] = 0; m_t[k] = 0;
              if (want) m_press[k] = 1'b1; else m_rel[k] = 1'b1;
            end
          end else begin
            if (m_lvl[k] && m_run[k] == 0) begin
              m_t[k]++;
              if (REP && (m_t[k] == RDLY || (m_t[k] > RDLY && (m_t[k] - RDLY) % RRATE == 0)))
                m_rpt[k] = 1'b1;
            end
            m_run[k] = 0;
          end
          m_state[k] = m_lvl[k];
          m_s2[k] = m_s1[k];
          m_s1[k] = key_in[k];
        end
        m_valid = |m_press;
        m_code  = '0;
        for (int k = N - 1; k >= 0; k--) if (m_press[k]) m_code = 2'(k);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_on)
        chk("cycle_outputs",
            {13'd0, key_state, key_press, key_release, key_repeat, key_valid, key_code},
            {13'd0, m_state, m_press, m_rel, m_rpt, m_valid, m_code});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen, nrep, first, last;
    bit got;
    logic [4:0] bnc;
    int tmr[N];

    key_in = '1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", {key_state, key_press, key_release, key_repeat, key_valid, key_code}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // clean press of key 2
    key_in[2] = 1'b0;
    repeat (18) @(posedge clk);
    #1 chk("press2_early", key_press, 4'b0000);
    @(posedge clk);
    #1 chk("press2", key_press, 4'b0100);
    chk("press2_code", key_code, 2);
    chk("press2_valid", key_valid, 1);
    @(posedge clk);
    #1 chk("press2_one_cycle", key_press, 4'b0000);
    chk("press2_state", key_state, 4'b0100);

    // 10-cycle glitch on key 0
    @(negedge clk) key_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    key_in[0] = 1'b1;
    seen = 0;
    repeat (30) begin @(posedge clk); #1 if (key_press[0] || key_state[0]) seen++; end
    chk("glitch_no_press", seen, 0);

    // release of key 2 with a 5-cycle bounce
    bnc = 5'b00101;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) key_in[2] = bnc[i];
      @(posedge clk);
      #1 chk("bounce_state_held", key_state[2], 1);
    end
    @(negedge clk) key_in[2] = 1'b1;
    repeat (18) @(posedge clk);
    #1 chk("rel2_early", key_release, 4'b0000);
    chk("rel2_state_held", key_state[2], 1);
    @(posedge clk);
    #1 chk("rel2", key_release, 4'b0100);
    chk("rel2_state", key_state, 4'b0000);

    // keys 1 and 3 together
    repeat (5) @(negedge clk);
    key_in[1] = 1'b0; key_in[3] = 1'b0;
    repeat (19) @(posedge clk);
    #1 chk("dual_press", key_press, 4'b1010);
    chk("dual_valid", key_valid, 1);
    chk("dual_code", key_code, 1);
    @(negedge clk) key_in = '1;
    repeat (40) @(negedge clk);

    // auto-repeat on key 0
    key_in[0] = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin @(posedge clk); #1 if (key_press[0]) got = 1'b1; end
    chk("rpt_press_seen", got, 1);
    nrep = 0; first = 0; last = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1 if (key_repeat[0]) begin nrep++; if (nrep == 1) first = c; last = c; end
    end
    if (REP) begin
      chk("rpt_count", nrep, 5);
      chk("rpt_first", first, 64);
      chk("rpt_last", last, 192);
    end else begin
      chk("rpt_count_off", nrep, 0);
    end
    @(negedge clk) key_in[0] = 1'b1;
    repeat (30) @(negedge clk);

    // reset while key 2 is held
    key_in[2] = 1'b0;
    repeat (25) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("in_reset_zero", {key_state, key_press, key_release, key_repeat, key_valid, key_code}, 0);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (18) @(posedge clk);
    #1 chk("post_reset_early", key_press, 4'b0000);
    @(posedge clk);
    #1 chk("post_reset_press", key_press, 4'b0100);
    @(negedge clk) key_in = '1;
    repeat (30) @(negedge clk);

    // random phase, checked every cycle by the model
    for (int k = 0; k < N; k++) tmr[k] = 0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 999) != 0);
      for (int k = 0; k < N; k++) begin
        if (tmr[k] == 0) begin
          key_in[k] = ($urandom_range(0, 1) == 1);
          tmr[k] = ($urandom_range(0, 5) == 0) ? $urandom_range(60, 160) : $urandom_range(1, 30);
        end else begin
          tmr[k]--;
        end
      end
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
